// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl
// Sequences one Sobel frame: it loads pixels from a streaming sink, issues a
// 3x3 window every cycle over all interior positions, waits for the kernel
// pipeline to drain, then streams the gradients out to a streaming source.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   start_i                 rising edge in IDLE starts a frame
//   snk_valid_i/sop_i/eop_i pixel stream sideband; snk_ready_o high in LOAD
//   img_wr_o, img_addr_o    pixel memory write strobe and raster address
//   calc_o, win_row_o/col_o window issue strobe and top-left corner
//   g_wr_o, g_wr_addr_o     gradient write, calc_o delayed KERNEL_LAT cycles
//   src_valid_o/sop_o/eop_o output stream sideband, src_ready_i back-pressure
//   g_rd_addr_o             gradient read address (combinational memory)
//   idle_o, done_o, err_o   status: idle, end-of-frame pulse, sticky framing error
module sobel_stream_ctrl #(
    parameter int  IMG_W      = 8,
    parameter int  IMG_H      = 8,
    parameter int  KERNEL_LAT = 2,
    localparam int NPIX       = IMG_W * IMG_H,
    localparam int NOUT       = (IMG_W - 2) * (IMG_H - 2),
    localparam int AW         = $clog2(NPIX),
    localparam int GW         = (NOUT > 1) ? $clog2(NOUT) : 1,
    localparam int CW         = $clog2(IMG_W),
    localparam int RW         = $clog2(IMG_H)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          snk_valid_i,
    input  logic          snk_sop_i,
    input  logic          snk_eop_i,
    output logic          snk_ready_o,
    output logic          img_wr_o,
    output logic [AW-1:0] img_addr_o,
    output logic          calc_o,
    output logic [RW-1:0] win_row_o,
    output logic [CW-1:0] win_col_o,
    output logic          g_wr_o,
    output logic [GW-1:0] g_wr_addr_o,
    output logic          src_valid_o,
    output logic          src_sop_o,
    output logic          src_eop_o,
    input  logic          src_ready_i,
    output logic [GW-1:0] g_rd_addr_o,
    output logic          idle_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int            FW       = (KERNEL_LAT > 1) ? $clog2(KERNEL_LAT) : 1;
    localparam logic [AW-1:0] PC_LAST  = AW'(NPIX - 1);
    localparam logic [GW-1:0] K_LAST   = GW'(NOUT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 3);
    localparam logic [FW-1:0] FC_LAST  = FW'(KERNEL_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FLUSH, S_OUT} state_t;

    state_t        state_q, state_d;
    logic          start_q;
    logic          err_q;
    logic [AW-1:0] pc_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [GW-1:0] k_q;
    logic [GW-1:0] oc_q;
    logic [FW-1:0] fc_q;

    logic          start_edge;
    logic          clr_cnt;
    logic          beat_restart;
    logic          beat_err;

    logic          vld_p   [KERNEL_LAT];
    logic [GW-1:0] gaddr_p [KERNEL_LAT];

    assign start_edge = start_i & ~start_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idle_o       = 1'b0;
        snk_ready_o  = 1'b0;
        img_wr_o     = 1'b0;
        img_addr_o   = pc_q;
        calc_o       = 1'b0;
        src_valid_o  = 1'b0;
        src_sop_o    = 1'b0;
        src_eop_o    = 1'b0;
        done_o       = 1'b0;
        clr_cnt      = 1'b0;
        beat_restart = 1'b0;
        beat_err     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idle_o = 1'b1;
                if (start_edge) begin
                    clr_cnt = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                snk_ready_o = 1'b1;
                if (snk_valid_i) begin
                    if (pc_q == '0 && !snk_sop_i) begin
                        // Frame has not begun yet: drop the stray beat.
                        beat_err = 1'b1;
                    end else begin
                        img_wr_o = 1'b1;
                        if (snk_sop_i && pc_q != '0) begin
                            // Unexpected sop restarts the frame at pixel 0.
                            beat_restart = 1'b1;
                            beat_err     = 1'b1;
                            img_addr_o   = '0;
                            if (snk_eop_i) begin
                                state_d = S_IDLE;
                            end
                        end else if (pc_q == PC_LAST) begin
                            beat_err = ~snk_eop_i;
                            state_d  = S_CALC;
                        end else if (snk_eop_i) begin
                            beat_err = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                end
            end
            S_CALC: begin
                calc_o = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fc_q == FC_LAST) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                src_valid_o = 1'b1;
                src_sop_o   = (oc_q == '0);
                src_eop_o   = (oc_q == K_LAST);
                if (src_ready_i && oc_q == K_LAST) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // start_q resets high so a start_i already high at reset release is not an edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            start_q <= 1'b1;
            err_q   <= 1'b0;
            pc_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            oc_q    <= '0;
            fc_q    <= '0;
        end else begin
            start_q <= start_i;
            if (clr_cnt) begin
                err_q <= 1'b0;
                pc_q  <= '0;
                row_q <= '0;
                col_q <= '0;
                k_q   <= '0;
                oc_q  <= '0;
                fc_q  <= '0;
            end
            if (beat_err) begin
                err_q <= 1'b1;
            end
            if (beat_restart) begin
                pc_q <= AW'(1);
            end else if (img_wr_o && pc_q != PC_LAST) begin
                pc_q <= pc_q + 1'b1;
            end
            if (calc_o) begin
                k_q <= k_q + 1'b1;
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (state_q == S_FLUSH) begin
                fc_q <= fc_q + 1'b1;
            end
            if (src_valid_o && src_ready_i && oc_q != K_LAST) begin
                oc_q <= oc_q + 1'b1;
            end
        end
    end

    // Kernel latency stages: valid is reset so a reset flushes pending writes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < KERNEL_LAT; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= calc_o;
            for (int i = 1; i < KERNEL_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        gaddr_p[0] <= k_q;
        for (int i = 1; i < KERNEL_LAT; i++) begin
            gaddr_p[i] <= gaddr_p[i-1];
        end
    end

    assign g_wr_o      = vld_p[KERNEL_LAT-1];
    assign g_wr_addr_o = g_wr_o ? gaddr_p[KERNEL_LAT-1] : '0;
    assign g_rd_addr_o = oc_q;
    assign win_row_o   = row_q;
    assign win_col_o   = col_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
`timescale 1ns/1ps
module tb_sobel_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, start, sel;
    logic snk_valid, snk_sop, snk_eop, src_ready;
    logic a_start, b_start;
    assign a_start = start & ~sel;
    assign b_start = start & sel;

    // DUT A: 4x4, latency 2
    logic       a_snk_ready, a_img_wr, a_calc, a_g_wr, a_src_valid, a_src_sop, a_src_eop;
    logic       a_idle, a_done, a_err;
    logic [3:0] a_img_addr;
    logic [1:0] a_row, a_col, a_g_wr_addr, a_g_rd;

    // DUT B: 5x3, latency 4
    logic       b_snk_ready, b_img_wr, b_calc, b_g_wr, b_src_valid, b_src_sop, b_src_eop;
    logic       b_idle, b_done, b_err;
    logic [3:0] b_img_addr;
    logic [1:0] b_row, b_g_wr_addr, b_g_rd;
    logic [2:0] b_col;

    sobel_stream_ctrl #(.IMG_W(4), .IMG_H(4), .KERNEL_LAT(2)) u_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(a_start),
        .snk_valid_i(snk_valid), .snk_sop_i(snk_sop), .snk_eop_i(snk_eop),
        .snk_ready_o(a_snk_ready), .img_wr_o(a_img_wr), .img_addr_o(a_img_addr),
        .calc_o(a_calc), .win_row_o(a_row), .win_col_o(a_col),
        .g_wr_o(a_g_wr), .g_wr_addr_o(a_g_wr_addr),
        .src_valid_o(a_src_valid), .src_sop_o(a_src_sop), .src_eop_o(a_src_eop),
        .src_ready_i(src_ready), .g_rd_addr_o(a_g_rd),
        .idle_o(a_idle), .done_o(a_done), .err_o(a_err)
    );

    sobel_stream_ctrl #(.IMG_W(5), .IMG_H(3), .KERNEL_LAT(4)) u_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(b_start),
        .snk_valid_i(snk_valid), .snk_sop_i(snk_sop), .snk_eop_i(snk_eop),
        .snk_ready_o(b_snk_ready), .img_wr_o(b_img_wr), .img_addr_o(b_img_addr),
        .calc_o(b_calc), .win_row_o(b_row), .win_col_o(b_col),
        .g_wr_o(b_g_wr), .g_wr_addr_o(b_g_wr_addr),
        .src_valid_o(b_src_valid), .src_sop_o(b_src_sop), .src_eop_o(b_src_eop),
        .src_ready_i(src_ready), .g_rd_addr_o(b_g_rd),
        .idle_o(b_idle), .done_o(b_done), .err_o(b_err)
    );

    // Observation view of the selected instance
    logic       o_snk_ready, o_img_wr, o_calc, o_g_wr, o_src_valid, o_src_sop, o_src_eop;
    logic       o_idle, o_done, o_err;
    logic [7:0] o_img_addr, o_row, o_col, o_g_addr, o_g_rd;
    assign o_snk_ready = sel ? b_snk_ready : a_snk_ready;
    assign o_img_wr    = sel ? b_img_wr    : a_img_wr;
    assign o_calc      = sel ? b_calc      : a_calc;
    assign o_g_wr      = sel ? b_g_wr      : a_g_wr;
    assign o_src_valid = sel ? b_src_valid : a_src_valid;
    assign o_src_sop   = sel ? b_src_sop   : a_src_sop;
    assign o_src_eop   = sel ? b_src_eop   : a_src_eop;
    assign o_idle      = sel ? b_idle      : a_idle;
    assign o_done      = sel ? b_done      : a_done;
    assign o_err       = sel ? b_err       : a_err;
    assign o_img_addr  = sel ? 8'(b_img_addr)  : 8'(a_img_addr);
    assign o_row       = sel ? 8'(b_row)       : 8'(a_row);
    assign o_col       = sel ? 8'(b_col)       : 8'(a_col);
    assign o_g_addr    = sel ? 8'(b_g_wr_addr) : 8'(a_g_wr_addr);
    assign o_g_rd      = sel ? 8'(b_g_rd)      : 8'(a_g_rd);

    int cur_w, cur_h, cur_lat;
    int errors = 0;
    int checks = 0;

    bit q_sop[$];
    bit q_eop[$];

    int m_wr[$], m_cr[$], m_cc[$], m_ccyc[$], m_ga[$], m_gcyc[$];
    int m_oa[$], m_os[$], m_oe[$], m_ocyc[$], m_dcyc[$];
    int first_vld = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Event recorder for the selected instance
    bit         p_hold = 1'b0;
    logic [7:0] p_addr;
    logic       p_sop, p_eop;
    always @(negedge clk) begin
        if (o_img_wr) m_wr.push_back(int'(o_img_addr));
        if (o_calc) begin
            m_cr.push_back(int'(o_row));
            m_cc.push_back(int'(o_col));
            m_ccyc.push_back(cyc);
        end
        if (o_g_wr) begin
            m_ga.push_back(int'(o_g_addr));
            m_gcyc.push_back(cyc);
        end
        if (o_src_valid && first_vld < 0) first_vld = cyc;
        if (o_src_valid && src_ready) begin
            m_oa.push_back(int'(o_g_rd));
            m_os.push_back(int'(o_src_sop));
            m_oe.push_back(int'(o_src_eop));
            m_ocyc.push_back(cyc);
        end
        if (o_done) m_dcyc.push_back(cyc);
        if (p_hold && o_src_valid) begin
            chk("hold_stable", {o_g_rd, o_src_sop, o_src_eop}, {p_addr, p_sop, p_eop});
        end
        p_hold = o_src_valid && !src_ready;
        p_addr = o_g_rd;
        p_sop  = o_src_sop;
        p_eop  = o_src_eop;
    end

    task automatic clr_mon();
        m_wr.delete(); m_cr.delete(); m_cc.delete(); m_ccyc.delete();
        m_ga.delete(); m_gcyc.delete(); m_oa.delete(); m_os.delete();
        m_oe.delete(); m_ocyc.delete(); m_dcyc.delete();
        first_vld = -1;
    endtask

    task automatic mk_clean(input int n);
        q_sop.delete(); q_eop.delete();
        for (int i = 0; i < n; i++) begin
            q_sop.push_back(i == 0);
            q_eop.push_back(i == n - 1);
        end
    endtask

    task automatic do_start(output int s_cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random gaps
    task automatic drive_beats(input int mode);
        int i = 0;
        int g = 0;
        bit v;
        while (i < q_sop.size() && g < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (g % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            snk_valid = v; snk_sop = q_sop[i]; snk_eop = q_eop[i];
            @(negedge clk);
            if (g == 0) begin
                chk("load_entry_idle", o_idle, 0);
                chk("load_entry_ready", o_snk_ready, 1);
                chk("load_entry_err", o_err, 0);
            end
            v = v & o_snk_ready;
            @(posedge clk); #1;
            if (v) i++;
            g++;
        end
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        chk("beats_accepted", i, q_sop.size());
    endtask

    // bpmode 0: ready high, 1: ready low every other cycle, 2: random
    task automatic wait_idle(input int bpmode);
        int g = 0;
        while (g < 3000) begin
            case (bpmode)
                0:       src_ready = 1'b1;
                1:       src_ready = (g % 2 == 1);
                default: src_ready = ($urandom_range(0, 1) == 1);
            endcase
            @(negedge clk);
            if (o_idle) break;
            @(posedge clk); #1;
            g++;
        end
        chk("idle_reached", o_idle, 1);
        src_ready = 1'b1;
        repeat (cur_lat + 4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string nm, input int s_cyc, input bit unstalled);
        int  np, no, pc, k, last;
        bit  err, fin, abort;
        int  exp_wr[$];
        np = cur_w * cur_h;
        no = (cur_w - 2) * (cur_h - 2);
        pc = 0; err = 0; fin = 0; abort = 0;
        for (int i = 0; i < q_sop.size(); i++) begin
            if (fin || abort) break;
            if (pc == 0 && !q_sop[i]) begin
                err = 1;
                continue;
            end
            if (q_sop[i] && pc != 0) begin
                err = 1;
                pc = 0;
            end
            exp_wr.push_back(pc);
            if (pc == np - 1) begin
                if (!q_eop[i]) err = 1;
                fin = 1;
            end else if (q_eop[i]) begin
                err = 1;
                abort = 1;
            end else begin
                pc++;
            end
        end
        chk({nm, ":n_img_wr"}, m_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < m_wr.size(); i++)
            chk({nm, ":img_addr"}, m_wr[i], exp_wr[i]);
        chk({nm, ":err"}, o_err, err);
        if (fin) begin
            chk({nm, ":n_calc"}, m_cr.size(), no);
            k = 0;
            for (int r = 0; r < cur_h - 2; r++) begin
                for (int c = 0; c < cur_w - 2; c++) begin
                    if (k < m_cr.size()) begin
                        chk({nm, ":win_row"}, m_cr[k], r);
                        chk({nm, ":win_col"}, m_cc[k], c);
                        chk({nm, ":calc_consec"}, m_ccyc[k], m_ccyc[0] + k);
                    end
                    k++;
                end
            end
            chk({nm, ":n_g_wr"}, m_ga.size(), no);
            for (int i = 0; i < m_ga.size() && i < m_ccyc.size(); i++) begin
                chk({nm, ":g_wr_addr"}, m_ga[i], i);
                chk({nm, ":g_wr_lat"}, m_gcyc[i], m_ccyc[i] + cur_lat);
            end
            chk({nm, ":n_out"}, m_oa.size(), no);
            for (int i = 0; i < m_oa.size(); i++) begin
                chk({nm, ":out_addr"}, m_oa[i], i);
                chk({nm, ":out_sop"}, m_os[i], (i == 0) ? 1 : 0);
                chk({nm, ":out_eop"}, m_oe[i], (i == no - 1) ? 1 : 0);
            end
            if (m_ccyc.size() > 0) begin
                last = m_ccyc[m_ccyc.size() - 1];
                chk({nm, ":flush_len"}, first_vld, last + cur_lat + 1);
            end
            chk({nm, ":n_done"}, m_dcyc.size(), 1);
            if (m_dcyc.size() > 0 && m_ocyc.size() > 0)
                chk({nm, ":done_at_last"}, m_dcyc[0], m_ocyc[m_ocyc.size() - 1]);
            if (unstalled && m_dcyc.size() > 0)
                chk({nm, ":frame_cycles"}, m_dcyc[0] - (s_cyc - 1) + 1, 1 + np + no + cur_lat + no);
        end else begin
            chk({nm, ":n_calc"}, m_cr.size(), 0);
            chk({nm, ":n_g_wr"}, m_ga.size(), 0);
            chk({nm, ":n_out"}, m_oa.size(), 0);
            chk({nm, ":n_done"}, m_dcyc.size(), 0);
        end
    endtask

    task automatic run_frame(input string nm, input int dmode, input int bpmode, input bit unstalled);
        int s;
        clr_mon();
        do_start(s);
        drive_beats(dmode);
        wait_idle(bpmode);
        check_frame(nm, s, unstalled);
    endtask

    initial begin
        int  g;
        int  s;
        bit  found;
        rst_n = 1'b0; start = 1'b0; sel = 1'b0;
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; src_ready = 1'b1;
        cur_w = 4; cur_h = 4; cur_lat = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", a_idle, 1);
        chk("rst_outputs", {a_snk_ready, a_img_wr, a_calc, a_g_wr, a_src_valid, a_src_sop, a_src_eop, a_done, a_err}, 0);
        chk("rst_addrs", {a_img_addr, a_row, a_col, a_g_wr_addr, a_g_rd}, 0);
        chk("rst_b_idle", b_idle, 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_start", a_idle, 1);

        mk_clean(16);
        run_frame("clean", 0, 0, 1);
        run_frame("stall", 1, 1, 0);

        q_sop.delete(); q_eop.delete();
        for (int i = 0; i < 10; i++) begin
            q_sop.push_back(i == 0);
            q_eop.push_back(i == 9);
        end
        run_frame("early_eop", 0, 0, 0);
        mk_clean(16);
        run_frame("after_err", 0, 0, 1);

        mk_clean(16);
        q_sop.push_front(1'b0);
        q_eop.push_front(1'b0);
        run_frame("no_sop", 0, 0, 0);

        // Reset while the third window is being issued
        mk_clean(16);
        clr_mon();
        do_start(s);
        drive_beats(0);
        g = 0; found = 0;
        while (g < 50 && !found) begin
            @(negedge clk);
            if (o_calc && o_row == 8'd1 && o_col == 8'd0) found = 1;
            g++;
        end
        chk("rst_mid:reach_k2", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid:idle", a_idle, 1);
        chk("rst_mid:outputs", {a_snk_ready, a_img_wr, a_calc, a_g_wr, a_src_valid, a_done, a_err}, 0);
        chk("rst_mid:addrs", {a_img_addr, a_row, a_col, a_g_wr_addr, a_g_rd}, 0);
        clr_mon();
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid:no_g_wr", m_gcyc.size(), 0);
        chk("rst_mid:no_calc", m_ccyc.size(), 0);
        chk("rst_mid:no_retrigger", a_idle, 1);
        start = 1'b0;
        @(posedge clk);
        #1;
        mk_clean(16);
        run_frame("post_rst", 0, 0, 1);

        for (int t = 0; t < 3; t++) begin
            mk_clean(16);
            run_frame("rand_a", 2, 2, 0);
        end

        sel = 1'b1;
        cur_w = 5; cur_h = 3; cur_lat = 4;
        @(posedge clk);
        #1;
        mk_clean(15);
        run_frame("b_clean", 0, 0, 1);
        run_frame("b_rand", 2, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
